// File: rtl/imem_boot_loader.sv
// Boot loader: receives a framed byte stream (SYNC, LEN_HI, LEN_LO, 4*N data bytes), packs words into imem and holds the CPU in reset until the load completes.
// Optional trailing checksum byte is enabled with macro IMEM_LOADER_CHECKSUM_EN; the word write lands one cycle after the 4th byte and rx_ready drops only in DONE.
module imem_boot_loader #(
    parameter int          ADDR_W = 10,
    parameter logic [7:0]  SYNC   = 8'hA5
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    input  logic [31:0] cpu_pc_i,
    output logic [31:0] imem_addr_o,
    output logic [31:0] imem_data_o,
    output logic        imem_we_o,
    output logic        cpu_rst_o,
    output logic        load_done_o,
    output logic        error_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CHK,
        S_FLUSH,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    state_t              state_q;
    state_t              state_d;
    logic [7:0]          len_hi_q;
    logic [15:0]         len_q;
    logic [ADDR_W:0]     word_idx_q;
    logic [1:0]          byte_idx_q;
    logic [23:0]         asm_q;
    logic [31:0]         wr_data_q;
    logic                we_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]          csum_q;
`endif

    logic        accept;
    logic        is_sync;
    logic [15:0] len_full;
    logic        last_word;

    assign accept    = rx_valid_i && (state_q != S_DONE);
    assign is_sync   = (rx_data_i == SYNC);
    assign len_full  = {len_hi_q, rx_data_i};
    // word_idx_q still names the word being assembled when its 4th byte arrives
    assign last_word = ({{(16-ADDR_W){1'b0}}, word_idx_q} == ({1'b0, len_q} - 17'd1));

    assign rx_ready_o  = (state_q != S_DONE);
    assign cpu_rst_o   = (state_q != S_DONE);
    assign load_done_o = (state_q == S_DONE);
    assign error_o     = (state_q == S_ERROR);
    assign imem_we_o   = we_q;
    assign imem_data_o = wr_data_q;
    assign imem_addr_o = (state_q == S_DONE) ? cpu_pc_i
                                             : {{(32-ADDR_W){1'b0}}, word_idx_q[ADDR_W-1:0]};

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept && is_sync) begin
                    state_d = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    if ({1'b0, len_full} > MAX_WORDS) begin
                        state_d = S_ERROR;
                    end else if (len_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept && (byte_idx_q == 2'd3) && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_FLUSH;
`endif
                end
            end
            S_CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (accept) begin
                    state_d = (rx_data_i == csum_q) ? S_DONE : S_ERROR;
                end
`else
                state_d = S_ERROR;
`endif
            end
            S_FLUSH: begin
                // last word is being written this cycle; release the core after it lands
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            S_ERROR: begin
                if (accept && is_sync) begin
                    state_d = S_LEN_HI;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            len_hi_q   <= '0;
            len_q      <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            asm_q      <= '0;
            wr_data_q  <= '0;
            we_q       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            we_q <= 1'b0;
            if (we_q) begin
                word_idx_q <= word_idx_q + 1'b1;
            end
            if (accept) begin
                case (state_q)
                    S_IDLE, S_ERROR: begin
                        if (is_sync) begin
                            word_idx_q <= '0;
                            byte_idx_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            csum_q     <= '0;
`endif
                        end
                    end
                    S_LEN_HI: begin
                        len_hi_q <= rx_data_i;
                    end
                    S_LEN_LO: begin
                        len_q <= len_full;
                    end
                    S_DATA: begin
                        asm_q      <= {asm_q[15:0], rx_data_i};
                        byte_idx_q <= byte_idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_q     <= csum_q + rx_data_i;
`endif
                        if (byte_idx_q == 2'd3) begin
                            wr_data_q <= {asm_q, rx_data_i};
                            we_q      <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: random frames against a word-list reference model, plus directed frames from the datasheet.
module tb_imem_boot_loader;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] cpu_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        imem_we;
    logic        cpu_rst;
    logic        load_done;
    logic        error;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];

    imem_boot_loader dut (
        .CLK        (CLK),
        .RST        (RST),
        .rx_data_i  (rx_data),
        .rx_valid_i (rx_valid),
        .rx_ready_o (rx_ready),
        .cpu_pc_i   (cpu_pc),
        .imem_addr_o(imem_addr),
        .imem_data_o(imem_data),
        .imem_we_o  (imem_we),
        .cpu_rst_o  (cpu_rst),
        .load_done_o(load_done),
        .error_o    (error)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (imem_we) begin
            got_addr.push_back(imem_addr);
            got_data.push_back(imem_data);
        end
    end

    task automatic apply_reset;
        @(negedge CLK);
        RST = 1'b1;
        rx_valid = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        got_addr.delete();
        got_data.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        repeat ($urandom_range(0, 2)) @(negedge CLK);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge CLK);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    // Reference frame: header, MSB-first words, and the mod-256 byte sum when checksums are built in.
    task automatic send_frame(input logic [31:0] words[$], input bit corrupt);
        logic [7:0]  sum;
        logic [15:0] n;
        sum = 8'h00;
        n = 16'(words.size());
        send_byte(8'hA5);
        send_byte(n[15:8]);
        send_byte(n[7:0]);
        foreach (words[i]) begin
            for (int k = 3; k >= 0; k--) begin
                sum = sum + words[i][8*k +: 8];
                send_byte(words[i][8*k +: 8]);
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(corrupt ? ~sum : sum);
`else
        if (corrupt) send_byte(8'h00);
`endif
    endtask

    task automatic wait_settle(input string name);
        int cyc;
        cyc = 0;
        while (!load_done && !error && cyc < 40) begin
            @(negedge CLK);
            cyc++;
        end
        repeat (2) @(negedge CLK);
        n_checks++;
        if (cyc >= 40) $display("FAIL %s settle: timed out waiting for done/error", name);
        else n_pass++;
    endtask

    task automatic test_reset;
        apply_reset();
        n_checks++; if (rx_ready !== 1'b1) $display("FAIL reset rx_ready got %b exp 1", rx_ready); else n_pass++;
        n_checks++; if (cpu_rst !== 1'b1) $display("FAIL reset cpu_rst got %b exp 1", cpu_rst); else n_pass++;
        n_checks++; if (imem_we !== 1'b0) $display("FAIL reset imem_we got %b exp 0", imem_we); else n_pass++;
        n_checks++; if (load_done !== 1'b0) $display("FAIL reset load_done got %b exp 0", load_done); else n_pass++;
        n_checks++; if (error !== 1'b0) $display("FAIL reset error got %b exp 0", error); else n_pass++;
        n_checks++; if (imem_data !== 32'h0) $display("FAIL reset imem_data got %h exp 0", imem_data); else n_pass++;
        n_checks++; if (imem_addr !== 32'h0) $display("FAIL reset imem_addr got %h exp 0", imem_addr); else n_pass++;
    endtask

    task automatic test_basic;
        logic [31:0] exp[$];
        logic [31:0] pc;
        exp = '{32'hDEADBEEF, 32'h00000001};
        apply_reset();
        send_frame(exp, 1'b0);
        wait_settle("basic");
        n_checks++; if (got_addr.size() !== exp.size()) $display("FAIL basic write count got %0d exp %0d", got_addr.size(), exp.size()); else n_pass++;
        for (int i = 0; i < exp.size() && i < got_addr.size(); i++) begin
            n_checks++;
            if (got_addr[i] !== 32'(i) || got_data[i] !== exp[i]) $display("FAIL basic write %0d got %h@%h exp %h@%h", i, got_data[i], got_addr[i], exp[i], i);
            else n_pass++;
        end
        n_checks++; if (load_done !== 1'b1) $display("FAIL basic load_done got %b exp 1", load_done); else n_pass++;
        n_checks++; if (cpu_rst !== 1'b0) $display("FAIL basic cpu_rst got %b exp 0", cpu_rst); else n_pass++;
        n_checks++; if (rx_ready !== 1'b0) $display("FAIL basic rx_ready got %b exp 0", rx_ready); else n_pass++;
        n_checks++; if (error !== 1'b0) $display("FAIL basic error got %b exp 0", error); else n_pass++;
        cpu_pc = 32'h5;
        #1;
        n_checks++; if (imem_addr !== 32'h5) $display("FAIL basic pc passthru got %h exp 5", imem_addr); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            pc = $urandom;
            cpu_pc = pc;
            #1;
            n_checks++; if (imem_addr !== pc) $display("FAIL basic pc follow got %h exp %h", imem_addr, pc); else n_pass++;
        end
        // bytes offered after completion must be ignored
        send_byte(8'hA5);
        repeat (3) @(negedge CLK);
        n_checks++; if (got_addr.size() !== 2 || load_done !== 1'b1) $display("FAIL basic sticky done writes %0d done %b exp 2/1", got_addr.size(), load_done); else n_pass++;
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum;
        logic [31:0] exp[$];
        logic [31:0] none[$];
        exp = '{32'hDEADBEEF, 32'h00000001};
        apply_reset();
        send_frame(exp, 1'b1);
        wait_settle("chk_bad");
        n_checks++; if (error !== 1'b1 || cpu_rst !== 1'b1) $display("FAIL chk_bad error/cpu_rst got %b/%b exp 1/1", error, cpu_rst); else n_pass++;
        n_checks++; if (got_addr.size() !== 2) $display("FAIL chk_bad writes kept got %0d exp 2", got_addr.size()); else n_pass++;
        send_frame(none, 1'b0);
        wait_settle("chk_recover");
        n_checks++; if (load_done !== 1'b1 || error !== 1'b0) $display("FAIL chk_recover done/error got %b/%b exp 1/0", load_done, error); else n_pass++;
    endtask
`endif

    task automatic test_junk;
        logic [31:0] exp[$];
        exp = '{32'h12345678};
        apply_reset();
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h13);
        send_frame(exp, 1'b0);
        wait_settle("junk");
        n_checks++; if (got_addr.size() !== 1) $display("FAIL junk write count got %0d exp 1", got_addr.size()); else n_pass++;
        n_checks++; if (got_addr.size() > 0 && (got_addr[0] !== 32'h0 || got_data[0] !== 32'h12345678)) $display("FAIL junk write got %h@%h exp 12345678@0", got_data[0], got_addr[0]); else n_pass++;
        n_checks++; if (load_done !== 1'b1) $display("FAIL junk load_done got %b exp 1", load_done); else n_pass++;
    endtask

    task automatic test_overflow;
        logic [31:0] none[$];
        apply_reset();
        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(8'h01);
        wait_settle("ovf");
        n_checks++; if (error !== 1'b1 || cpu_rst !== 1'b1 || rx_ready !== 1'b1) $display("FAIL ovf error/cpu_rst/rx_ready got %b/%b/%b exp 1/1/1", error, cpu_rst, rx_ready); else n_pass++;
        send_byte(8'h00);
        send_byte(8'h3C);
        repeat (2) @(negedge CLK);
        n_checks++; if (error !== 1'b1 || load_done !== 1'b0) $display("FAIL ovf junk error/done got %b/%b exp 1/0", error, load_done); else n_pass++;
        send_frame(none, 1'b0);
        wait_settle("ovf_recover");
        n_checks++; if (load_done !== 1'b1 || error !== 1'b0) $display("FAIL ovf_recover done/error got %b/%b exp 1/0", load_done, error); else n_pass++;
        n_checks++; if (got_addr.size() !== 0) $display("FAIL ovf writes got %0d exp 0", got_addr.size()); else n_pass++;
    endtask

    task automatic test_random_frames;
        logic [31:0] exp[$];
        logic [7:0]  junk;
        for (int f = 0; f < 6; f++) begin
            exp.delete();
            repeat ($urandom_range(1, 6)) exp.push_back($urandom);
            apply_reset();
            repeat ($urandom_range(0, 3)) begin
                junk = 8'($urandom);
                if (junk == 8'hA5) junk = 8'h5A;
                send_byte(junk);
            end
            send_frame(exp, 1'b0);
            wait_settle("rand");
            n_checks++; if (got_addr.size() !== exp.size()) $display("FAIL rand%0d write count got %0d exp %0d", f, got_addr.size(), exp.size()); else n_pass++;
            for (int i = 0; i < exp.size() && i < got_addr.size(); i++) begin
                n_checks++;
                if (got_addr[i] !== 32'(i) || got_data[i] !== exp[i]) $display("FAIL rand%0d write %0d got %h@%h exp %h@%h", f, i, got_data[i], got_addr[i], exp[i], i);
                else n_pass++;
            end
            n_checks++; if (load_done !== 1'b1 || cpu_rst !== 1'b0) $display("FAIL rand%0d done/cpu_rst got %b/%b exp 1/0", f, load_done, cpu_rst); else n_pass++;
        end
    endtask

    task automatic test_max_len;
        logic [31:0] exp[$];
        int bad;
        for (int i = 0; i < 1024; i++) exp.push_back($urandom);
        apply_reset();
        send_frame(exp, 1'b0);
        wait_settle("maxlen");
        n_checks++; if (got_addr.size() !== 1024) $display("FAIL maxlen write count got %0d exp 1024", got_addr.size()); else n_pass++;
        bad = 0;
        for (int i = 0; i < exp.size() && i < got_addr.size(); i++)
            if (got_addr[i] !== 32'(i) || got_data[i] !== exp[i]) bad++;
        n_checks++; if (bad != 0) $display("FAIL maxlen write contents got %0d bad words exp 0", bad); else n_pass++;
        n_checks++; if (load_done !== 1'b1) $display("FAIL maxlen load_done got %b exp 1", load_done); else n_pass++;
    endtask

    task automatic test_reset_midload;
        logic [31:0] exp[$];
        int cyc;
        exp = '{$urandom, $urandom, $urandom};
        apply_reset();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h03);
        for (int i = 0; i < 2; i++)
            for (int k = 3; k >= 0; k--) send_byte(exp[i][8*k +: 8]);
        cyc = 0;
        while (got_addr.size() < 2 && cyc < 10) begin
            @(negedge CLK);
            cyc++;
        end
        n_checks++; if (got_addr.size() !== 2) $display("FAIL midload writes before reset got %0d exp 2", got_addr.size()); else n_pass++;
        apply_reset();
        n_checks++; if (rx_ready !== 1'b1 || cpu_rst !== 1'b1 || imem_we !== 1'b0) $display("FAIL midload rx_ready/cpu_rst/we got %b/%b/%b exp 1/1/0", rx_ready, cpu_rst, imem_we); else n_pass++;
        n_checks++; if (load_done !== 1'b0 || error !== 1'b0 || imem_data !== 32'h0 || imem_addr !== 32'h0) $display("FAIL midload done/error/data/addr got %b/%b/%h/%h exp 0/0/0/0", load_done, error, imem_data, imem_addr); else n_pass++;
        exp = '{$urandom, $urandom};
        send_frame(exp, 1'b0);
        wait_settle("midload_fresh");
        n_checks++; if (got_addr.size() !== 2) $display("FAIL midload fresh write count got %0d exp 2", got_addr.size()); else n_pass++;
        for (int i = 0; i < exp.size() && i < got_addr.size(); i++) begin
            n_checks++;
            if (got_addr[i] !== 32'(i) || got_data[i] !== exp[i]) $display("FAIL midload fresh write %0d got %h@%h exp %h@%h", i, got_data[i], got_addr[i], exp[i], i);
            else n_pass++;
        end
        n_checks++; if (load_done !== 1'b1) $display("FAIL midload fresh load_done got %b exp 1", load_done); else n_pass++;
    endtask

    initial begin
        RST      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        cpu_pc   = 32'h0;
        test_reset();
        test_basic();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_junk();
        test_overflow();
        test_random_frames();
        test_max_len();
        test_reset_midload();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
